// File: rtl/looper_pkg.sv
// Shared constants and state encoding for the SPI write/read paths.
package looper_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_BITS  = 16;
  localparam int unsigned FRAME_BITS = 48;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StHold
  } spiState_e;

endpackage

// File: rtl/spi_sync.sv
// Metastability synchronizer for one SPI line, with history flop and
// registered rise/fall pulses aligned with the delayed level.
module spi_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   synced;

  assign synced = stages[SYNC_STAGES-1];

  // Resetting to 0 means a line held low through reset never shows a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      stages <= SYNC_STAGES'({stages, din});
      level  <= synced;
      rise   <= synced & ~level;
      fall   <= ~synced & level;
    end
  end

endmodule

// File: rtl/spi_write_slave.sv
// SPI write slave: oversamples a mode-0 SPI host and turns each complete
// 48-bit address/data frame into a single-cycle RAM write strobe.
module spi_write_slave #(
  parameter int unsigned ADDR_W      = looper_pkg::ADDR_W,
  parameter int unsigned DATA_W      = looper_pkg::DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ss,
  input  logic              mosi,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] last_addr,
  output logic              frame_err,
  output logic              busy
);

  import looper_pkg::*;

  localparam int unsigned FrameBits = ADDR_W + DATA_W;
  localparam int unsigned CntW      = $clog2(FrameBits + 1);

  localparam logic [CntW-1:0] CntAddrLast = CntW'(ADDR_W - 1);
  localparam logic [CntW-1:0] CntLast     = CntW'(FrameBits - 1);
  localparam logic [CntW-1:0] CntFull     = CntW'(FrameBits);

  spiState_e            state;
  logic [CntW-1:0]      bitCnt;
  logic [FrameBits-1:0] shiftReg;
  logic                 commit;

  logic sckRise, ssRise, ssFall, mosiBit;
  logic unusedSckLevel, unusedSckFall, unusedSsLevel, unusedMosiRise, unusedMosiFall;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk  (clk),
    .rst  (rst),
    .din  (sck),
    .level(unusedSckLevel),
    .rise (sckRise),
    .fall (unusedSckFall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clk  (clk),
    .rst  (rst),
    .din  (ss),
    .level(unusedSsLevel),
    .rise (ssRise),
    .fall (ssFall)
  );

  // mosi level is taken from the history flop so it lines up with sckRise.
  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk  (clk),
    .rst  (rst),
    .din  (mosi),
    .level(mosiBit),
    .rise (unusedMosiRise),
    .fall (unusedMosiFall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      bitCnt    <= '0;
      shiftReg  <= '0;
      commit    <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      last_addr <= '0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_en     <= commit;
      commit    <= 1'b0;
      frame_err <= 1'b0;
      // The shift register is stable for at least one cycle after completion.
      if (commit) begin
        wr_addr   <= shiftReg[FrameBits-1 -: ADDR_W];
        wr_data   <= shiftReg[DATA_W-1:0];
        last_addr <= shiftReg[FrameBits-1 -: ADDR_W];
      end
      unique case (state)
        StIdle: begin
          if (ssFall) begin
            bitCnt <= '0;
            state  <= StAddr;
            busy   <= 1'b1;
          end
        end
        StAddr, StData: begin
          if (sckRise && bitCnt == CntLast) begin
            // Last bit wins over a coincident ss release.
            shiftReg <= {shiftReg[FrameBits-2:0], mosiBit};
            bitCnt   <= CntFull;
            commit   <= 1'b1;
            state    <= ssRise ? StIdle : StHold;
            busy     <= ~ssRise;
          end else if (ssRise) begin
            frame_err <= 1'b1;
            state     <= StIdle;
            busy      <= 1'b0;
          end else if (sckRise) begin
            shiftReg <= {shiftReg[FrameBits-2:0], mosiBit};
            bitCnt   <= bitCnt + 1'b1;
            if (bitCnt == CntAddrLast) begin
              state <= StData;
            end
          end
        end
        StHold: begin
          if (ssRise) begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
